// File: rtl/axis_bus_sel_arbiter_pkg.sv
// Shared constants and types for the AXIS bus_sel arbiter and the mux/demux pair it drives.
package axis_bus_sel_arbiter_pkg;

  localparam int N_CH_DEFAULT = 10;

  localparam logic [7:0] SEL_BASE        = 8'd128;
  localparam logic [7:0] NON_FIFO_CHOOSE = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // A single channel still needs a one-bit index vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_bus_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to the lowest.
module axis_rr_pick
  import axis_bus_sel_arbiter_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int IDX_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scanning downward leaves the lowest qualifying index in each candidate.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    found  = lo_found;
    winner = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/axis_bus_sel_arbiter.sv
// Packet-granular round-robin arbiter producing the registered bus_sel code for the AXIS mux/demux.
module axis_bus_sel_arbiter #(
  parameter int         N_CH            = 10,
  parameter logic [7:0] SEL_BASE        = 8'd128,
  parameter logic [7:0] NON_FIFO_CHOOSE = 8'd0,
  parameter int         TIMEOUT_CYCLES  = 1024,
  parameter int         TMO_W           = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N_CH-1:0] ch_req,
  input  logic            axis_in_tvalid,
  input  logic            axis_in_tready,
  input  logic            axis_in_tlast,
  output logic [7:0]      bus_sel,
  output logic [N_CH-1:0] grant_onehot,
  output logic            busy,
  output logic            timeout_err,
  output logic [7:0]      timeout_ch
);

  import axis_bus_sel_arbiter_pkg::*;

  localparam int IDX_W = idx_width(N_CH);
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] grant_idx, grant_nxt;
  logic [TMO_W-1:0] tmo_cnt, cnt_nxt;
  logic             tmo_fire;

  logic             pick_found;
  logic [IDX_W-1:0] pick_winner;
  logic             beat, eop, expire;
  logic [IDX_W-1:0] ptr_after;
  logic [N_CH-1:0]  onehot_nxt;
  logic [7:0]       bus_sel_nxt;

  axis_rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (ch_req),
    .ptr    (ptr),
    .found  (pick_found),
    .winner (pick_winner)
  );

  assign beat      = axis_in_tvalid & axis_in_tready;
  assign eop       = beat & axis_in_tlast;
  // Expiry is the stalled cycle that would bring the count to TIMEOUT_CYCLES; any beat pre-empts it.
  assign expire    = WD_ON && !beat && (tmo_cnt == TMO_LIMIT);
  assign ptr_after = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_idx;
    cnt_nxt   = tmo_cnt;
    tmo_fire  = 1'b0;
    unique case (state)
      ST_IDLE, ST_RELEASE: begin
        if (enable && pick_found) begin
          state_nxt = ST_GRANT;
          grant_nxt = pick_winner;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (eop) begin
          state_nxt = ST_RELEASE;
          ptr_nxt   = ptr_after;
          cnt_nxt   = '0;
        end else if (expire) begin
          state_nxt = ST_RELEASE;
          ptr_nxt   = ptr_after;
          cnt_nxt   = '0;
          tmo_fire  = 1'b1;
        end else if (beat) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    onehot_nxt  = '0;
    bus_sel_nxt = NON_FIFO_CHOOSE;
    if (state_nxt == ST_GRANT) begin
      onehot_nxt[grant_nxt] = 1'b1;
      bus_sel_nxt           = SEL_BASE + 8'(grant_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_idx <= grant_nxt;
      tmo_cnt   <= cnt_nxt;
    end
  end

  // Outputs are registered from next-state values so bus_sel tracks the state with no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_sel      <= NON_FIFO_CHOOSE;
      grant_onehot <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      timeout_ch   <= 8'd0;
    end else begin
      bus_sel      <= bus_sel_nxt;
      grant_onehot <= onehot_nxt;
      busy         <= (state_nxt == ST_GRANT);
      timeout_err  <= tmo_fire;
      if (tmo_fire) begin
        timeout_ch <= 8'(grant_idx);
      end
    end
  end

endmodule

// File: tb/tb_axis_bus_sel_arbiter.sv
// Randomized and directed bench for axis_bus_sel_arbiter against a packet-level reference model.
module tb_axis_bus_sel_arbiter;

  localparam int N_CH = 10;
  localparam int TMO  = 8;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic [N_CH-1:0] ch_req;
  logic            axis_in_tvalid;
  logic            axis_in_tready;
  logic            axis_in_tlast;
  logic [7:0]      bus_sel;
  logic [N_CH-1:0] grant_onehot;
  logic            busy;
  logic            timeout_err;
  logic [7:0]      timeout_ch;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, where the search starts, and how long the owner has stalled.
  int         m_owner;
  int         m_ptr;
  int         m_stall;
  logic       m_terr;
  logic [7:0] m_tch;

  axis_bus_sel_arbiter #(
    .N_CH            (N_CH),
    .SEL_BASE        (8'd128),
    .NON_FIFO_CHOOSE (8'd0),
    .TIMEOUT_CYCLES  (TMO),
    .TMO_W           (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .ch_req         (ch_req),
    .axis_in_tvalid (axis_in_tvalid),
    .axis_in_tready (axis_in_tready),
    .axis_in_tlast  (axis_in_tlast),
    .bus_sel        (bus_sel),
    .grant_onehot   (grant_onehot),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .timeout_ch     (timeout_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_ptr   = 0;
    m_stall = 0;
    m_terr  = 1'b0;
    m_tch   = 8'd0;
  endtask

  // One clock edge of the arbitration rules, evaluated on the inputs the bench is driving.
  task automatic modelStep();
    m_terr = 1'b0;
    if (m_owner >= 0) begin
      if (axis_in_tvalid && axis_in_tready) begin
        m_stall = 0;
        if (axis_in_tlast) begin
          m_ptr   = (m_owner + 1) % N_CH;
          m_owner = -1;
        end
      end else begin
        m_stall++;
        if (TMO != 0 && m_stall == TMO) begin
          m_terr  = 1'b1;
          m_tch   = 8'(m_owner);
          m_ptr   = (m_owner + 1) % N_CH;
          m_owner = -1;
        end
      end
    end else if (enable && ch_req != '0) begin
      for (int k = 0; k < N_CH; k++) begin
        if (m_owner < 0 && ch_req[(m_ptr + k) % N_CH]) begin
          m_owner = (m_ptr + k) % N_CH;
          m_stall = 0;
        end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_bus_sel"}, 32'(bus_sel), (m_owner >= 0) ? 32'(128 + m_owner) : 32'd0);
    checkOutput({tag, "_onehot"}, 32'(grant_onehot), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    checkOutput({tag, "_terr"}, 32'(timeout_err), 32'(m_terr));
    checkOutput({tag, "_tch"}, 32'(timeout_ch), 32'(m_tch));
  endtask

  // Drive one cycle of inputs from a negedge, step the model on the posedge, check on the next negedge.
  task automatic applyStimulus(input logic en, input logic [N_CH-1:0] req,
                               input logic tv, input logic tr, input logic tl, input string tag);
    enable         = en;
    ch_req         = req;
    axis_in_tvalid = tv;
    axis_in_tready = tr;
    axis_in_tlast  = tl;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll(tag);
  endtask

  // Asserts rst_n between clock edges and checks the outputs react without waiting for a clock.
  task automatic applyReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] rr_exp [7];

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    ch_req         = '1;
    axis_in_tvalid = 1'b0;
    axis_in_tready = 1'b0;
    axis_in_tlast  = 1'b0;
    modelReset();
    @(negedge clk);
    checkAll("por");

    // Reset with every channel requesting, then first grant after release.
    applyReset("reset");
    applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, "first");
    checkOutput("first_grant", 32'(bus_sel), 32'd128);

    // Round robin over channels 0, 2, 5 with single-beat packets.
    applyReset("rr_rst");
    rr_exp = '{8'd128, 8'd0, 8'd130, 8'd0, 8'd133, 8'd0, 8'd128};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 10'b0000100101, 1'b1, 1'b1, 1'b1, "rr");
      checkOutput($sformatf("rr_seq%0d", i), 32'(bus_sel), 32'(rr_exp[i]));
    end

    // Packet lock on ch3 with tready toggling and the request dropping mid-packet.
    applyReset("lock_rst");
    applyStimulus(1'b1, 10'h008, 1'b0, 1'b0, 1'b0, "lock_g");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, (i == 0) ? 10'h008 : 10'h000, 1'b1, (i % 2) == 0 || i == 5, i == 5, "lock");
      checkOutput("lock_hold", 32'(bus_sel), (i == 5) ? 32'd0 : 32'd131);
    end
    applyStimulus(1'b1, 10'h000, 1'b0, 1'b0, 1'b0, "lock_idle");

    // Watchdog: ch7 stalls for TMO cycles, then the search resumes at ch8.
    applyReset("wd_rst");
    applyStimulus(1'b1, 10'h080, 1'b0, 1'b0, 1'b0, "wd_g");
    for (int i = 0; i < TMO; i++) applyStimulus(1'b1, 10'h080, 1'b1, 1'b0, 1'b0, "wd");
    checkOutput("wd_err", 32'(timeout_err), 32'd1);
    checkOutput("wd_ch", 32'(timeout_ch), 32'd7);
    checkOutput("wd_gap", 32'(bus_sel), 32'd0);
    applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, "wd_next");
    checkOutput("wd_next_sel", 32'(bus_sel), 32'd136);
    checkOutput("wd_err_pulse", 32'(timeout_err), 32'd0);

    // Tlast beat landing in the cycle that would otherwise expire the watchdog.
    applyReset("eop_rst");
    applyStimulus(1'b1, 10'h080, 1'b0, 1'b0, 1'b0, "eop_g");
    for (int i = 0; i < TMO - 1; i++) applyStimulus(1'b1, 10'h080, 1'b1, 1'b0, 1'b0, "eop_stall");
    applyStimulus(1'b1, 10'h080, 1'b1, 1'b1, 1'b1, "eop_last");
    checkOutput("eop_wins", 32'(timeout_err), 32'd0);

    // Enable falls mid-packet: the packet finishes, then no further grants.
    applyReset("en_rst");
    applyStimulus(1'b1, 10'h003, 1'b0, 1'b0, 1'b0, "en_g");
    applyStimulus(1'b0, 10'h003, 1'b1, 1'b1, 1'b0, "en_mid");
    checkOutput("en_hold", 32'(bus_sel), 32'd128);
    applyStimulus(1'b0, 10'h003, 1'b1, 1'b1, 1'b1, "en_last");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 10'h003, 1'b0, 1'b0, 1'b0, "en_off");
      checkOutput("en_idle", 32'(bus_sel), 32'd0);
    end

    // Async reset in the middle of a ch5 packet, after the pointer has moved past ch2.
    applyReset("ar_rst");
    applyStimulus(1'b1, 10'h004, 1'b0, 1'b0, 1'b0, "ar_g2");
    applyStimulus(1'b1, 10'h004, 1'b1, 1'b1, 1'b1, "ar_eop");
    applyStimulus(1'b1, 10'h024, 1'b0, 1'b0, 1'b0, "ar_g5");
    checkOutput("ar_ch5", 32'(bus_sel), 32'd133);
    applyStimulus(1'b1, 10'h024, 1'b1, 1'b1, 1'b0, "ar_mid");
    applyReset("ar_midrst");
    checkOutput("ar_zero", 32'(bus_sel), 32'd0);
    applyStimulus(1'b1, 10'h024, 1'b0, 1'b0, 1'b0, "ar_first");
    checkOutput("ar_lowest", 32'(bus_sel), 32'd130);

    // Random traffic.
    applyReset("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 8) != 0,
                    (($urandom % 4) == 0) ? 10'h000 : N_CH'($urandom),
                    ($urandom % 2) == 0,
                    ($urandom % 2) == 0,
                    ($urandom % 4) == 0,
                    "rnd");
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
